plru_tree_array: RTL and testbench
==================================

Name: plru_tree_array

Overview:
- Per-set tree pseudo-LRU state store for N-way set-associative caches; generalises the single-bit 2-way PLRU array to any power-of-two associativity.
- Separate read (victim lookup) port and update (touch) port, so the lookup stage and hit/fill stage of the two-cycle cache run concurrently.
- Victim selection prefers invalid ways.
- The victim is returned registered, one cycle after the lookup.

Parameters:
- s_index, 4: set index width; num_sets = 2**s_index.
- num_ways, 4: associativity; power of two, >= 2. Any other value is an elaboration-time $error.
- Derived: tree_w = num_ways-1 (tree bits per set); way_w = $clog2(num_ways).

Ports:
- clk0  in  1  clock; all state updates on rising edge.
- rst0_n  in  1  reset, asynchronous, active-low.
- csb0  in  1  read port select, active-low.
- addr0  in  s_index  read set index.
- valid_mask0  in  num_ways  per-way valid bits of the read set (bit w = way w valid).
- csb1  in  1  update port select, active-low.
- addr1  in  s_index  update set index.
- way1  in  way_w  way being touched (hit or fill).
- dout0  out  tree_w  registered tree bits of the last read set.
- plru_way  out  way_w  registered victim way for the last read.
- rd_valid  out  1  high the cycle after csb0 was low.

Behaviour:
- Tree encoding:
  - Node i has children 2i+1 and 2i+2; leaves map to ways 0..num_ways-1, left to right.
  - Node bit 0 means the victim lies left; 1 means right.
  - tree bit i is node i; bit 0 is the root.
- Touch(w): every node on the root-to-leaf path of way w is set to point away from w. Nodes off the path are unchanged.
- Victim(bits, mask):
  - If any mask bit is 0, the victim is the lowest-index invalid way.
  - Otherwise, walk from the root following the node bits.
- Reset (rst0_n low, asynchronous):
  - All tree bits of all sets are cleared to 0.
  - dout0 = 0, plru_way = 0, rd_valid = 0.
  - This takes effect immediately, including mid-operation.
  - Operations start on the first rising edge after rst0_n goes high.
- Read port, csb0 low at edge T:
  - At T, dout0 <= tree[addr0], plru_way <= Victim(tree[addr0], valid_mask0), rd_valid <= 1.
  - Latency is 1 cycle.
- Read port, csb0 high at edge T:
  - dout0 and plru_way hold their previous values.
  - rd_valid <= 0.
- Update port, csb1 low at edge T:
  - tree[addr1] <= Touch(tree[addr1], way1), as a single-cycle read-modify-write.
  - Back-to-back updates to the same set in consecutive cycles compose correctly.
- Simultaneous read and update to the same set (csb0 and csb1 low, addr0 == addr1):
  - The read forwards the post-update bits.
  - dout0 and plru_way reflect Touch applied.
- Simultaneous read and update to different sets are independent.
- An update never changes dout0 or plru_way unless forwarded by a same-cycle read.
- Reads do not modify state.
- No stall or backpressure: both ports accept every cycle.

Decomposition:
- Package plru_pkg:
  - Functions plru_touch(bits, way) and plru_victim(bits, mask), parametrised through a parameterised class or through sizing by max associativity.
  - Localparam helpers for tree_w and way_w.
- One combinational sub-module, plru_victim_sel (num_ways): tree bits + valid mask -> victim way.
  - Instanced once on the read path.
  - Reusable by the cache's replacement logic.
- Storage is flops: a num_sets x tree_w array with async clear. No SRAM macro.

Test Plan (num_ways=4, s_index=4, valid_mask0=4'b1111 unless stated):
- Reset, then read set 3 -> next cycle dout0=3'b000, plru_way=0, rd_valid=1. The cycle after, with csb0 high -> rd_valid=0 and outputs held.
- Touch set 5 way 0, then read set 5 -> dout0=3'b011, plru_way=2.
- Touch set 5 way 2, then read set 5 -> dout0=3'b110, plru_way=1. Set 4 still reads 3'b000.
- Touch set 7 ways 0,1,2,3 on consecutive cycles, then read -> dout0=3'b000, plru_way=0 (true LRU order for 4 ways).
- From reset, read and touch set 2 way 1 in the same cycle -> dout0=3'b001, plru_way=2 (forwarded).
- Read set 7 (tree 3'b000) with valid_mask0=4'b1011 -> plru_way=2.
- Reset mid-operation: after touches to sets 5 and 7, drive rst0_n low between edges -> outputs 0 immediately, and all sets read 3'b000 afterwards.

Source files
------------

// File: rtl/plru_tree_array_pkg.sv
// Shared tree pseudo-LRU helpers: sizing limits plus touch/victim functions
// sized by the largest supported associativity.
package plru_pkg;

    localparam int MAX_WAYS   = 32;
    localparam int MAX_TREE_W = MAX_WAYS - 1;
    localparam int MAX_WAY_W  = $clog2(MAX_WAYS);
    localparam int IDX_W      = $clog2(MAX_WAYS);

    function automatic int plru_tree_w(input int num_ways);
        return num_ways - 1;
    endfunction

    function automatic int plru_way_w(input int num_ways);
        return $clog2(num_ways);
    endfunction

    // Walk root-to-leaf along way's address bits, pointing each node away from it.
    function automatic logic [MAX_TREE_W-1:0] plru_touch(
        input logic [MAX_TREE_W-1:0] bits,
        input logic [MAX_WAY_W-1:0]  way,
        input int                    num_ways
    );
        logic [MAX_TREE_W-1:0] result;
        int   node;
        int   way_w;
        logic dir;
        result = bits;
        node   = 0;
        way_w  = plru_way_w(num_ways);
        for (int l = 0; l < MAX_WAY_W; l++) begin
            if (l < way_w) begin
                dir = ((int'(way) >> (way_w - 1 - l)) & 1) != 0;
                result[node[IDX_W-1:0]] = ~dir;
                node = 2 * node + 1 + int'(dir);
            end
        end
        return result;
    endfunction

    function automatic logic [MAX_WAY_W-1:0] plru_victim(
        input logic [MAX_TREE_W-1:0] bits,
        input logic [MAX_WAYS-1:0]   mask,
        input int                    num_ways
    );
        logic [MAX_WAY_W-1:0] result;
        logic found;
        int   node;
        int   way_w;
        result = '0;
        found  = 1'b0;
        way_w  = plru_way_w(num_ways);
        for (int w = 0; w < MAX_WAYS; w++) begin
            if (w < num_ways && !found && !mask[w[IDX_W-1:0]]) begin
                found  = 1'b1;
                result = MAX_WAY_W'(w);
            end
        end
        if (!found) begin
            node = 0;
            for (int l = 0; l < MAX_WAY_W; l++) begin
                if (l < way_w) node = 2 * node + 1 + int'(bits[node[IDX_W-1:0]]);
            end
            result = MAX_WAY_W'(node - (num_ways - 1));
        end
        return result;
    endfunction

endpackage

// File: rtl/plru_tree_array_if.sv
// Read (victim lookup) and update (touch) port bundle for the PLRU array.
interface plru_tree_array_if #(
    parameter int S_INDEX  = 4,
    parameter int NUM_WAYS = 4
);
    localparam int TREE_W = NUM_WAYS - 1;
    localparam int WAY_W  = $clog2(NUM_WAYS);

    logic                csb0;
    logic [S_INDEX-1:0]  addr0;
    logic [NUM_WAYS-1:0] valid_mask0;
    logic                csb1;
    logic [S_INDEX-1:0]  addr1;
    logic [WAY_W-1:0]    way1;
    logic [TREE_W-1:0]   dout0;
    logic [WAY_W-1:0]    plru_way;
    logic                rd_valid;

    modport master (
        output csb0, addr0, valid_mask0, csb1, addr1, way1,
        input  dout0, plru_way, rd_valid
    );

    modport slave (
        input  csb0, addr0, valid_mask0, csb1, addr1, way1,
        output dout0, plru_way, rd_valid
    );
endinterface

// File: rtl/plru_tree_array_victim_sel.sv
// Combinational victim picker: lowest invalid way, else follow the tree bits.
module plru_victim_sel
    import plru_pkg::*;
#(
    parameter  int NUM_WAYS = 4,
    localparam int TREE_W   = NUM_WAYS - 1,
    localparam int WAY_W    = $clog2(NUM_WAYS)
) (
    input  logic [TREE_W-1:0]   i_tree,
    input  logic [NUM_WAYS-1:0] i_mask,
    output logic [WAY_W-1:0]    o_way
);
    assign o_way = WAY_W'(plru_victim(MAX_TREE_W'(i_tree), MAX_WAYS'(i_mask), NUM_WAYS));
endmodule

// File: rtl/plru_tree_array.sv
// Per-set tree PLRU state in flops, with a registered victim-lookup port and
// an independent touch port; same-set touches forward into the lookup.
module plru_tree_array
    import plru_pkg::*;
#(
    parameter int S_INDEX  = 4,
    parameter int NUM_WAYS = 4
) (
    input logic              clk0,
    input logic              rst0_n,
    plru_tree_array_if.slave bus
);
    localparam int NUM_SETS = 2 ** S_INDEX;
    localparam int TREE_W   = plru_tree_w(NUM_WAYS);
    localparam int WAY_W    = plru_way_w(NUM_WAYS);

    if (NUM_WAYS < 2 || NUM_WAYS > MAX_WAYS || (NUM_WAYS & (NUM_WAYS - 1)) != 0) begin : g_bad_ways
        $error("plru_tree_array: NUM_WAYS must be a power of two in [2, %0d]", MAX_WAYS);
    end

    logic [TREE_W-1:0] r_tree [NUM_SETS];
    logic [TREE_W-1:0] r_dout;
    logic [WAY_W-1:0]  r_way;
    logic              r_rd_valid;

    logic [TREE_W-1:0] w_touched;
    logic [TREE_W-1:0] w_rd_bits;
    logic [WAY_W-1:0]  w_victim;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_touched = TREE_W'(plru_touch(MAX_TREE_W'(r_tree[bus.addr1]), MAX_WAY_W'(bus.way1), NUM_WAYS));
        w_rd_bits = r_tree[bus.addr0];
        if (!bus.csb1 && bus.addr1 == bus.addr0) w_rd_bits = w_touched;
    end

    plru_victim_sel #(.NUM_WAYS(NUM_WAYS)) u_victim_sel (
        .i_tree (w_rd_bits),
        .i_mask (bus.valid_mask0),
        .o_way  (w_victim)
    );

    // NOTE: the state array is plain flops, so it is cleared by reset like any register;
    // a real SRAM could not be, and would need a sweep after reset instead.
    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            for (int s = 0; s < NUM_SETS; s++) r_tree[s] <= '0;
        end else if (!bus.csb1) begin
            // NOTE: non-blocking so every flop samples pre-edge values and the read path sees old state.
            r_tree[bus.addr1] <= w_touched;
        end
    end

    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            r_dout     <= '0;
            r_way      <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= !bus.csb0;
            if (!bus.csb0) begin
                r_dout <= w_rd_bits;
                r_way  <= w_victim;
            end
        end
    end

    assign bus.dout0    = r_dout;
    assign bus.plru_way = r_way;
    assign bus.rd_valid = r_rd_valid;
endmodule

// File: tb/tb_plru_tree_array.sv
// Bench for plru_tree_array: directed scenarios plus random traffic against a
// leaf-upward reference model of the tree PLRU rules.
module tb_plru_tree_array;
    localparam int S_INDEX  = 4;
    localparam int NUM_WAYS = 4;
    localparam int NUM_SETS = 2 ** S_INDEX;
    localparam int FULL     = (1 << NUM_WAYS) - 1;

    logic clk0 = 1'b0;
    logic rst0_n;
    always #5 clk0 = ~clk0;

    plru_tree_array_if #(.S_INDEX(S_INDEX), .NUM_WAYS(NUM_WAYS)) bus ();

    plru_tree_array #(.S_INDEX(S_INDEX), .NUM_WAYS(NUM_WAYS)) dut (
        .clk0   (clk0),
        .rst0_n (rst0_n),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int model [NUM_SETS];
    int exp_dout, exp_way, exp_valid;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Touch: climb from the way's leaf to the root; each parent points at the sibling side.
    function automatic int ref_touch(input int bits, input int way);
        int n, p;
        n = way + NUM_WAYS - 1;
        while (n > 0) begin
            p = (n - 1) / 2;
            if (n % 2 == 1) bits = bits | (1 << p);
            else            bits = bits & ~(1 << p);
            n = p;
        end
        return bits;
    endfunction

    function automatic int ref_victim(input int bits, input int mask);
        int n;
        for (int w = 0; w < NUM_WAYS; w++)
            if (((mask >> w) & 1) == 0) return w;
        n = 0;
        while (n < NUM_WAYS - 1) n = 2 * n + 1 + ((bits >> n) & 1);
        return n - (NUM_WAYS - 1);
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, "_dout0"},    int'(bus.dout0),    exp_dout);
        check({tag, "_plru_way"}, int'(bus.plru_way), exp_way);
        check({tag, "_rd_valid"}, int'(bus.rd_valid), exp_valid);
    endtask

    // Called at a falling edge: drive, clock once, update the model, check, return at next falling edge.
    task automatic cycle(input bit c0, input int a0, input int mask,
                         input bit c1, input int a1, input int w1, input string tag);
        bus.csb0        = c0;
        bus.addr0       = S_INDEX'(a0);
        bus.valid_mask0 = NUM_WAYS'(mask);
        bus.csb1        = c1;
        bus.addr1       = S_INDEX'(a1);
        bus.way1        = 2'(w1);
        @(posedge clk0);
        if (!c1) model[a1] = ref_touch(model[a1], w1);
        exp_valid = !c0;
        if (!c0) begin
            exp_dout = model[a0];
            exp_way  = ref_victim(model[a0], mask);
        end
        #1;
        check_outputs(tag);
        @(negedge clk0);
    endtask

    task automatic clear_model();
        for (int s = 0; s < NUM_SETS; s++) model[s] = 0;
        exp_dout  = 0;
        exp_way   = 0;
        exp_valid = 0;
    endtask

    initial begin
        bit c0, c1;
        int a0, a1, w1, mask;

        rst0_n          = 1'b0;
        bus.csb0        = 1'b1;
        bus.csb1        = 1'b1;
        bus.addr0       = '0;
        bus.addr1       = '0;
        bus.way1        = '0;
        bus.valid_mask0 = '1;
        clear_model();
        #12;
        check_outputs("reset");
        @(negedge clk0);
        rst0_n = 1'b1;

        cycle(0, 3, FULL, 1, 0, 0, "rd_set3");
        check("plan_set3_dout", int'(bus.dout0), 0);
        cycle(1, 0, FULL, 1, 0, 0, "idle");
        check("plan_idle_valid", int'(bus.rd_valid), 0);

        cycle(1, 0, FULL, 0, 5, 0, "t5w0");
        cycle(0, 5, FULL, 1, 0, 0, "rd5a");
        check("plan_t5w0_dout", int'(bus.dout0), 3);
        check("plan_t5w0_way", int'(bus.plru_way), 2);
        cycle(1, 0, FULL, 0, 5, 2, "t5w2");
        cycle(0, 5, FULL, 1, 0, 0, "rd5b");
        check("plan_t5w2_dout", int'(bus.dout0), 6);
        check("plan_t5w2_way", int'(bus.plru_way), 1);
        cycle(0, 4, FULL, 1, 0, 0, "rd4");
        check("plan_set4_dout", int'(bus.dout0), 0);

        for (int w = 0; w < NUM_WAYS; w++) cycle(1, 0, FULL, 0, 7, w, "t7seq");
        cycle(0, 7, FULL, 1, 0, 0, "rd7");
        check("plan_lru_dout", int'(bus.dout0), 0);
        check("plan_lru_way", int'(bus.plru_way), 0);

        cycle(0, 2, FULL, 0, 2, 1, "fwd2");
        check("plan_fwd_dout", int'(bus.dout0), 1);
        check("plan_fwd_way", int'(bus.plru_way), 2);
        cycle(0, 7, 4'b1011, 1, 0, 0, "mask7");
        check("plan_mask_way", int'(bus.plru_way), 2);

        cycle(1, 0, FULL, 0, 5, 3, "t5w3");
        cycle(0, 5, FULL, 0, 7, 1, "rd5_t7");
        #2;
        rst0_n = 1'b0;
        #1;
        clear_model();
        check_outputs("async_rst");
        @(negedge clk0);
        rst0_n = 1'b1;
        for (int s = 0; s < NUM_SETS; s++) begin
            cycle(0, s, FULL, 1, 0, 0, "post_rst");
            check("post_rst_zero", int'(bus.dout0), 0);
        end

        for (int i = 0; i < 600; i++) begin
            c0   = ($urandom_range(0, 3) != 0) ? 1'b0 : 1'b1;
            c1   = ($urandom_range(0, 2) != 0) ? 1'b0 : 1'b1;
            a0   = (i % 2 == 0) ? $urandom_range(0, 3) : $urandom_range(0, NUM_SETS - 1);
            a1   = ($urandom_range(0, 1) == 0) ? a0 : $urandom_range(0, 3);
            w1   = $urandom_range(0, NUM_WAYS - 1);
            mask = ($urandom_range(0, 3) == 0) ? $urandom_range(0, FULL) : FULL;
            cycle(c0, a0, mask, c1, a1, w1, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
